// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 round-robin stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_rr_rr_pick.sv
// Combinational rotating-priority picker: returns the first requester after ptr,
// wrapping modulo N.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N  = 8,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          found
);

  localparam logic [SW:0] N_V = (SW+1)'(N);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_rot;
  logic [SW:0]    start;
  logic [SW:0]    off;
  logic [SW:0]    sum;

  // Doubling the vector lets a plain right shift stand in for a rotate.
  assign req_dbl = {req, req};
  assign start   = {1'b0, ptr} + (SW+1)'(1);
  assign req_rot = req_dbl >> start;
  assign found   = |req;

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        off = (SW+1)'(j);
      end
    end
    sum = start + off;
    if (sum >= N_V) begin
      sum = sum - N_V;
    end
    gnt_idx = sum[SW-1:0];
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin grant
// and a registered, channel-tagged output.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = clog2_min1(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [SW:0] N_V = (SW+1)'(N);

  logic [W-1:0]  ch_data [N];
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [SW-1:0] rr_idx;
  logic          rr_found;
  logic          fixed_found;
  logic [SW-1:0] chosen;
  logic          found;
  logic          load_en;
  logic          grant;

  rr_pick #(.N(N)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .found   (rr_found)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*W +: W];
      assign in_ready[gi] = grant && (chosen == SW'(gi));
    end
  endgenerate

  assign load_en     = !out_valid_q || out_ready;
  assign fixed_found = ({1'b0, sel} < N_V) && in_valid[sel];
  assign chosen      = (mode == MODE_RR) ? rr_idx   : sel;
  assign found       = (mode == MODE_RR) ? rr_found : fixed_found;
  // Reset gates the handshake so nothing is consumed while the register is cleared.
  assign grant       = load_en && found && !rst;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = grant;
      if (grant) begin
        out_data_d = ch_data[chosen];
        out_ch_d   = chosen;
        if (mode == MODE_RR) begin
          ptr_d = chosen;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: directed scenarios then random traffic,
// compared against a behavioural scoreboard model.
module tb_mux_nto1_rr;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_fails  = 0;

  // model state
  bit        m_valid;
  int        m_data;
  int        m_ch;
  int        m_ptr;

  mux_nto1_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_ch    = 0;
    m_ptr   = N - 1;
  endtask

  task automatic default_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'hA0 + 8'(k);
  endtask

  // One clock: check handshake before the edge, advance model, check outputs after.
  task automatic cycle();
    logic [N-1:0] er;
    bit  fnd;
    bit  load;
    int  k;
    #1;
    load = !m_valid || out_ready;
    fnd  = 1'b0;
    k    = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin
        fnd = 1'b1;
        k   = int'(sel);
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        if (!fnd && in_valid[(m_ptr + i) % N]) begin
          fnd = 1'b1;
          k   = (m_ptr + i) % N;
        end
      end
    end
    er = '0;
    if (!rst && load && fnd) er[k] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (load) begin
      if (fnd) begin
        m_valid = 1'b1;
        m_data  = int'(in_data[k*W +: W]);
        m_ch    = k;
        if (mode) m_ptr = k;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_ch",    32'(out_ch),    32'(m_ch));
    $display("cyc mode=%0d sel=%0d vld=%02h ordy=%0d rst=%0d -> irdy=%02h ov=%0d od=%02h och=%0d",
             mode, sel, in_valid, out_ready, rst, in_ready, out_valid, out_data, out_ch);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = '0; out_ready = 1'b0;
    default_data();
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    in_valid = 8'hFF;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;

    // RR fairness: 0..7,0 back to back
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("rr_seq", 32'(out_ch), 32'(i % N));
      chk("rr_nobubble", 32'(out_valid), 32'd1);
    end

    // reset mid-stream for two cycles
    rst = 1'b1;
    #1 chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_ch", 32'(out_ch), 32'd0);

    // fixed select
    mode = 1'b0; sel = 3'd5;
    #1 chk("fixed_ready", 32'(in_ready), 32'h20);
    cycle();
    chk("fixed_data", 32'(out_data), 32'hA5);
    chk("fixed_ch",   32'(out_ch),   32'd5);

    // skip and wrap: ptr still 0 from last RR grant
    mode = 1'b1; in_valid = 8'b0010_0100;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("skip_seq", 32'(out_ch), (i % 2 == 0) ? 32'd2 : 32'd5);
    end
    in_valid = 8'b0010_0101;
    cycle();
    chk("wrap_ch0", 32'(out_ch), 32'd0);

    // backpressure
    in_valid = 8'hFF;
    cycle();
    chk("bp_load", 32'(out_ch), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_hold_ch",   32'(out_ch),   32'd1);
      chk("bp_hold_data", 32'(out_data), 32'hA1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_resume", 32'(out_ch), 32'd2);

    // invalid selects
    mode = 1'b0; sel = 3'd3; in_valid = 8'hF7;
    cycle();
    chk("inv_sel_drain", 32'(out_valid), 32'd0);
    sel = 3'd7; in_valid = 8'h7F;
    cycle();
    chk("inv_sel7", 32'(out_valid), 32'd0);

    // random traffic
    for (int t = 0; t < 400; t++) begin
      if (!(in_valid != 0 && in_ready == 0 && !rst)) begin
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'($urandom);
      end
      in_valid  = 8'($urandom);
      mode      = 1'($urandom);
      sel       = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
